// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard
//
// Purpose:
//   Forwarding and load-use hazard unit for an in-order pipeline.
//   Destination registers of in-flight instructions are tracked in a
//   shift-register scoreboard that mirrors EX..WB:
//     - entry 0 is EX
//     - entry NSTAGES-1 is WB
//   For every source operand in ID the unit names the youngest stage
//   holding the value. When a load in EX feeds ID, the unit stalls ID
//   and inserts a bubble.
//
// Ports:
//   clk          pipeline clock
//   reset        asynchronous, active-high reset
//   id_valid     ID instruction is real (not a bubble)
//   id_dest      ID destination register
//   id_regwr     ID instruction writes a register
//   id_isload    ID instruction is a load
//   id_src       packed source indices; port p at [p*REGW +: REGW]
//   id_src_used  port p actually reads its source
//   stall_ext    external freeze; the whole scoreboard holds
//   flush        kill the ID instruction
//   fwd_sel      per-port select code:
//                  0   = register file
//                  k   = result of entry k-1
//   hz_stall     load-use stall request to PC/IFID
//   stall_cnt    hazard-stall cycle counter
//
// Optional feature:
//   Define FWD_HAZARD_PERFCNT_EN to build a saturating stall counter.
//   Without it, stall_cnt is tied to 0.
module fwd_hazard_scoreboard #(
  parameter int NPORTS  = 2,
  parameter int NSTAGES = 3,
  parameter int REGW    = 5,
  parameter int FSEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REGW-1:0]          id_dest,
  input  logic                     id_regwr,
  input  logic                     id_isload,
  input  logic [NPORTS*REGW-1:0]   id_src,
  input  logic [NPORTS-1:0]        id_src_used,
  input  logic                     stall_ext,
  input  logic                     flush,
  output logic [NPORTS*FSEL_W-1:0] fwd_sel,
  output logic                     hz_stall,
  output logic [31:0]              stall_cnt
);

  logic [NSTAGES-1:0]           sb_v;
  logic [NSTAGES-1:0]           sb_regwr;
  logic [NSTAGES-1:0][REGW-1:0] sb_dest;
  // Only the EX entry needs the load flag. Once a load has moved past EX,
  // its data is forwardable and it can no longer cause a stall.
  logic                         sb_isload0;

  logic [NPORTS-1:0][NSTAGES-1:0] match;
  logic [NPORTS-1:0]              hit_ex;

  // Match matrix for every (port, entry) pair.
  // A valid writer of r0 never matches, so register 0 always reads the
  // register file.
  always_comb begin
    match = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int k = 0; k < NSTAGES; k++) begin
        match[p][k] = sb_v[k] && sb_regwr[k] && (sb_dest[k] != '0) &&
                      (sb_dest[k] == id_src[p*REGW +: REGW]) &&
                      id_src_used[p] && id_valid;
      end
    end
  end

  // Priority select per port.
  // Entries are scanned oldest to youngest, so the lowest matching index
  // (the youngest producer) is the last to write and therefore wins.
  always_comb begin
    fwd_sel = '0;
    hit_ex  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int k = NSTAGES - 1; k >= 0; k--) begin
        if (match[p][k]) begin
          fwd_sel[p*FSEL_W +: FSEL_W] = FSEL_W'(k + 1);
        end
      end
      hit_ex[p] = match[p][0];
    end
  end

  // An entry-0 match is always the youngest match, so a load in EX that
  // feeds any port is a load-use hazard.
  // A flushed ID instruction is discarded anyway, so it never stalls.
  assign hz_stall = !flush && sb_isload0 && (|hit_ex);

  // Scoreboard shift register.
  // An external freeze holds everything. Otherwise the entries advance
  // one stage, and EX receives either the ID instruction or a bubble
  // (when it is flushed or held back by a load-use stall).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v       <= '0;
      sb_regwr   <= '0;
      sb_dest    <= '0;
      sb_isload0 <= 1'b0;
    end else if (!stall_ext) begin
      for (int k = NSTAGES - 1; k > 0; k--) begin
        sb_v[k]     <= sb_v[k-1];
        sb_regwr[k] <= sb_regwr[k-1];
        sb_dest[k]  <= sb_dest[k-1];
      end
      if (flush || hz_stall) begin
        sb_v[0]     <= 1'b0;
        sb_regwr[0] <= 1'b0;
        sb_dest[0]  <= '0;
        sb_isload0  <= 1'b0;
      end else begin
        sb_v[0]     <= id_valid;
        sb_regwr[0] <= id_regwr;
        sb_dest[0]  <= id_dest;
        sb_isload0  <= id_isload;
      end
    end
  end

`ifdef FWD_HAZARD_PERFCNT_EN
  logic [31:0] cnt_q;

  // Counts cycles actually lost to load-use bubbles.
  // Frozen cycles are not counted, and the count saturates instead of
  // wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (hz_stall && !stall_ext && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// tb_fwd_hazard_scoreboard
//
// Purpose:
//   Directed testbench for fwd_hazard_scoreboard with the default
//   parameters (NPORTS=2, NSTAGES=3, REGW=5, FSEL_W=2).
//
// Method:
//   Inputs are driven after the clock edge. The combinational outputs
//   are sampled 1 time unit later, well away from the active edge.
//   Expected values are worked out by hand from the pipeline position of
//   each issued instruction.
module tb_fwd_hazard_scoreboard;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_dest;
  logic        id_regwr;
  logic        id_isload;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        stall_ext;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        hz_stall;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_dest     (id_dest),
    .id_regwr    (id_regwr),
    .id_isload   (id_isload),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .stall_ext   (stall_ext),
    .flush       (flush),
    .fwd_sel     (fwd_sel),
    .hz_stall    (hz_stall),
    .stall_cnt   (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected counter value: the real count when the counter is built,
  // otherwise 0 because stall_cnt is tied off.
  function automatic logic [31:0] expCnt(input int n);
`ifdef FWD_HAZARD_PERFCNT_EN
    return 32'(n);
`else
    return 32'(0 * n);
`endif
  endfunction

  // Drives the ID instruction, then lets the combinational outputs settle.
  task automatic applyStimulus(
    input logic       valid,
    input logic [4:0] dest,
    input logic       regwr,
    input logic       isload,
    input logic [4:0] src0,
    input logic [4:0] src1,
    input logic [1:0] used
  );
    id_valid    = valid;
    id_dest     = dest;
    id_regwr    = regwr;
    id_isload   = isload;
    id_src      = {src1, src0};
    id_src_used = used;
    #1;
  endtask

  // Advances one clock edge and returns 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares both select codes, the stall request and the counter.
  task automatic checkOutput(
    input string       tag,
    input logic [1:0]  f0,
    input logic [1:0]  f1,
    input logic        hz,
    input logic [31:0] cnt
  );
    checks++;
    assert (fwd_sel[1:0] === f0) else begin
      errors++;
      $error("[TB] FAIL %s fwd_sel0 got %0d expected %0d", tag, fwd_sel[1:0], f0);
    end

    checks++;
    assert (fwd_sel[3:2] === f1) else begin
      errors++;
      $error("[TB] FAIL %s fwd_sel1 got %0d expected %0d", tag, fwd_sel[3:2], f1);
    end

    checks++;
    assert (hz_stall === hz) else begin
      errors++;
      $error("[TB] FAIL %s hz_stall got %0b expected %0b", tag, hz_stall, hz);
    end

    checks++;
    assert (stall_cnt === cnt) else begin
      errors++;
      $error("[TB] FAIL %s stall_cnt got %0d expected %0d", tag, stall_cnt, cnt);
    end
  endtask

  initial begin
    // Reset with every input idle.
    reset     = 1'b1;
    stall_ext = 1'b0;
    flush     = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b00);
    checkOutput("reset", 0, 0, 0, expCnt(0));
    @(negedge clk);
    reset = 1'b0;

    // add r3: no dependency of its own.
    applyStimulus(1, 3, 1, 0, 1, 2, 2'b11);
    checkOutput("add_r3_issue", 0, 0, 0, expCnt(0));
    tick();

    // Reader of r3 sees it in EX.
    applyStimulus(1, 0, 0, 0, 3, 3, 2'b01);
    checkOutput("r3_in_ex", 1, 0, 0, expCnt(0));
    tick();

    // r3 in MEM. Port 1 also names r3 but is unused.
    applyStimulus(1, 0, 0, 0, 3, 3, 2'b01);
    checkOutput("r3_in_mem", 2, 0, 0, expCnt(0));
    tick();

    // lw r5 issues while r3 is in WB.
    applyStimulus(1, 5, 1, 1, 3, 0, 2'b01);
    checkOutput("r3_in_wb", 3, 0, 0, expCnt(0));
    tick();

    // Load-use on port 1.
    applyStimulus(1, 0, 0, 0, 0, 5, 2'b10);
    checkOutput("loaduse_r5", 0, 1, 1, expCnt(0));
    tick();
    checkOutput("after_bubble_r5", 0, 2, 0, expCnt(1));
    tick();

    // Build r7 in entries 0 and 2, with a writer of r0 in entry 1.
    applyStimulus(1, 7, 1, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 0, 1, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 7, 1, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 0, 0, 0, 7, 7, 2'b11);
    checkOutput("r7_youngest", 1, 1, 0, expCnt(1));
    applyStimulus(0, 0, 0, 0, 7, 7, 2'b11);
    checkOutput("id_invalid", 0, 0, 0, expCnt(1));
    applyStimulus(1, 0, 0, 0, 0, 0, 2'b11);
    checkOutput("r0_never", 0, 0, 0, expCnt(1));

    // lw r9 into EX.
    // Entries are then: 0 = r9 (load), 1 = r7, 2 = r0 writer.
    applyStimulus(1, 9, 1, 1, 0, 0, 2'b00);
    tick();

    // Load-use while frozen: everything holds.
    applyStimulus(1, 0, 0, 0, 9, 7, 2'b11);
    stall_ext = 1'b1;
    #1;
    checkOutput("freeze_c0", 1, 2, 1, expCnt(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("freeze_hold", 1, 2, 1, expCnt(1));
    end
    stall_ext = 1'b0;
    #1;
    checkOutput("freeze_release", 1, 2, 1, expCnt(1));
    tick();
    checkOutput("after_release_bubble", 2, 3, 0, expCnt(2));
    tick();

    // lw r10 into EX.
    applyStimulus(1, 10, 1, 1, 0, 0, 2'b00);
    tick();

    // A dependent load lw r11 is flushed: no stall, and never tracked.
    applyStimulus(1, 11, 1, 1, 10, 0, 2'b01);
    flush = 1'b1;
    #1;
    checkOutput("flush_no_stall", 1, 0, 0, expCnt(2));
    tick();
    flush = 1'b0;
    applyStimulus(1, 0, 0, 0, 11, 10, 2'b11);
    checkOutput("flush_bubble", 0, 2, 0, expCnt(2));
    tick();
    checkOutput("flush_untracked", 0, 3, 0, expCnt(2));
    tick();

    // Three valid writers, then an asynchronous reset mid-cycle.
    applyStimulus(1, 12, 1, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 13, 1, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 14, 1, 0, 0, 0, 2'b00);
    tick();
    applyStimulus(1, 0, 0, 0, 12, 14, 2'b11);
    checkOutput("three_valid", 3, 1, 0, expCnt(2));
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 0, 0, 0, expCnt(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("post_reset", 0, 0, 0, expCnt(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-operand forwarding logic.
- Tracks in-flight destination registers internally in a shift-register scoreboard that mirrors the EX..WB pipeline, instead of taking stage registers as inputs.
- For each of NPORTS source operands in ID, produces a forward-select code naming the youngest producing stage.
- Detects load-use hazards and drives the ID stall itself, inserting a bubble.

Parameters:
- NPORTS, 2, number of source-operand read ports checked in ID.
- NSTAGES, 3, tracked stages after ID (entry 0 = EX, entry NSTAGES-1 = WB).
- REGW, 5, register-index width.
- FSEL_W, 2, width of each forward-select code; must satisfy 2^FSEL_W >= NSTAGES+1.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  instruction in ID is real (not a bubble).
- id_dest  in  REGW  destination register of the ID instruction.
- id_regwr  in  1  ID instruction writes a register.
- id_isload  in  1  ID instruction is a load (result available one stage later than ALU results).
- id_src  in  NPORTS*REGW  packed source register indices; port p at bits [p*REGW +: REGW].
- id_src_used  in  NPORTS  port p actually reads its source.
- stall_ext  in  1  external freeze (e.g. memory wait); holds the whole scoreboard.
- flush  in  1  kill the ID instruction (taken branch/jump).
- fwd_sel  out  NPORTS*FSEL_W  per-port select: 0 = register file, k = result of entry k-1.
- hz_stall  out  1  load-use stall request to PC/IFID.
- stall_cnt  out  32  hazard-stall cycle counter (optional feature only).

Behaviour:
- Scoreboard state: NSTAGES entries of {v, dest, regwr, isload}.
- Reset (asynchronous): all v=0, stall_cnt=0. Outputs are therefore fwd_sel=0 and hz_stall=0 until a valid entry exists.
- Match for port p at entry k requires all of:
  - v[k] and regwr[k];
  - dest[k] != 0;
  - dest[k] == src_p;
  - id_src_used[p];
  - id_valid.
- Forwarding is combinational. fwd_sel[p] = k+1 for the lowest matching k (youngest wins), else 0. Register 0 never forwards.
- Load-use: hz_stall = 1 when, for any port, the youngest match is entry 0 and isload[0]=1.
  - hz_stall is forced to 0 when flush=1.
  - While hz_stall=1, fwd_sel is still driven (don't-care for the consumer).
- Clock-edge update, in priority order:
  1. stall_ext=1: all entries hold. Counter is not incremented.
  2. flush=1 or hz_stall=1: entries shift (k -> k+1, entry NSTAGES-1 drops) and entry 0 loads a bubble (v=0).
  3. Otherwise: shift, and entry 0 loads {id_valid, id_dest, id_regwr, id_isload}.
- Latency: an instruction issued at edge n is at entry k during cycle n+k, and is forwardable from entry k to ID in that cycle.
- A load in entry 0 stalls the dependent instruction exactly one cycle. Next cycle the load is at entry 1 and fwd_sel = 2.
- Simultaneous hz_stall and stall_ext: hold wins. hz_stall stays asserted as long as the condition persists.
- Reset mid-operation clears all entries immediately, without waiting for the clock.

Optional Feature:
- Macro: FWD_HAZARD_PERFCNT_EN.
- Defined:
  - stall_cnt increments by 1 on each edge where hz_stall=1 and stall_ext=0.
  - Saturates at 32'hFFFF_FFFF (no wrap).
  - Cleared by reset.
- Not defined: stall_cnt is tied to 0 and no counter flops exist.

Test Plan:
- Reset, then issue add r3 (regwr=1, isload=0); next cycle ID reads r3 on port 0 -> fwd_sel[0]=1, hz_stall=0. Following cycle, an ID read of r3 -> fwd_sel[0]=2.
- Issue lw r5 (isload=1), then ID reads r5 on port 1 -> hz_stall=1 for exactly one cycle. Next cycle fwd_sel[1]=2, hz_stall=0, entry 0 v=0. stall_cnt=1 with FWD_HAZARD_PERFCNT_EN.
- r7 in entries 0 and 2 (both ALU) and ID reads r7 on both ports -> fwd_sel = {1,1}. Reads of r0 with a writer to r0 in flight -> fwd_sel=0.
- Load-use condition with stall_ext=1 for 3 cycles -> entries unchanged, hz_stall held at 1, counter unchanged. Release -> one bubble inserted, counter +1.
- flush=1 while the ID instruction is a load dependent on entry 0 -> hz_stall=0, entry 0 becomes a bubble next edge, and the ID instruction is never tracked.
- Assert reset asynchronously mid-sequence with 3 valid entries -> fwd_sel=0, hz_stall=0 before the next clk edge; stall_cnt=0.
